uart_frame_tx: RTL and testbench

Serial transmitter that sits directly downstream of the PC-report sequencer. It accepts a 40-bit report word over a level send/send_done handshake and shifts it out on the UART TX pin as five 8N1 bytes. The most-significant byte goes first; bits within each byte go LSB first. The line idles high between transfers.

---
 rtl/uart_defs.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_frame_tx.sv | 135 +++++++++++++
 tb/tb_uart_frame_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the PC-report UART transmitter: report width,
// default baud divisor and the frame FSM state encoding.
package uart_defs;

   localparam int SendToPC         = 39;
   localparam int SendToPCSize     = 40;
   localparam int CLKS_PER_BIT_DEF = 434;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      START = ST_START,
      DATA  = ST_DATA,
      STOP  = ST_STOP,
      DONE  = ST_DONE
   } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// cycle of each bit; restart holds the count at zero between frames.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = !restart && (cnt == LAST_CNT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// Sends a latched DATA_W-bit report as NBYTES 8N1 bytes, MSB byte first,
// LSB-first bits, under a four-phase send/send_done handshake.
module uart_frame_tx
   import uart_defs::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_W       = SendToPCSize,
   parameter int NBYTES       = DATA_W / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send,
   input  logic [DATA_W-1:0] data,
   output logic              send_done,
   output logic              tx,
   output logic              busy
);

   localparam int BYTE_W = $clog2(NBYTES) + 1;
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

   uart_state_t       state, state_next;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic [2:0]        bit_idx, bit_idx_next;
   logic [BYTE_W-1:0] byte_idx, byte_idx_next;
   logic              tx_next, busy_next, done_next;
   logic              tick, restart;
   logic [7:0]        cur_byte;

   assign cur_byte = shreg[DATA_W-1 -: 8];

   // Baud timer only runs while a frame is on the line.
   assign restart = (state == IDLE) || (state == DONE);

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .restart(restart),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         send_done <= 1'b0;
      end else begin
         state     <= state_next;
         shreg     <= shreg_next;
         bit_idx   <= bit_idx_next;
         byte_idx  <= byte_idx_next;
         tx        <= tx_next;
         busy      <= busy_next;
         send_done <= done_next;
      end
   end

   // Outputs are computed for the next state so they land registered in it.
   always_comb begin
      state_next    = state;
      shreg_next    = shreg;
      bit_idx_next  = bit_idx;
      byte_idx_next = byte_idx;
      tx_next       = tx;
      busy_next     = busy;
      done_next     = send_done;
      case (state)
         IDLE: begin
            if (send) begin
               state_next    = START;
               shreg_next    = data;
               byte_idx_next = '0;
               bit_idx_next  = '0;
               tx_next       = 1'b0;
               busy_next     = 1'b1;
               done_next     = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_next   = DATA;
               bit_idx_next = '0;
               tx_next      = cur_byte[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  tx_next      = cur_byte[bit_idx + 3'd1];
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (byte_idx != LAST_BYTE) begin
                  state_next    = START;
                  shreg_next    = shreg << 8;
                  byte_idx_next = byte_idx + BYTE_W'(1);
                  tx_next       = 1'b0;
               end else begin
                  state_next = DONE;
                  tx_next    = 1'b1;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end
            end
         end
         DONE: begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
            if (!send) begin
               state_next = IDLE;
               done_next  = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx at 4 clocks per bit: stimulus queues the
// expected bytes, a line monitor decodes tx and compares.
module tb_uart_frame_tx;

   localparam int CPB = 4;

   logic        clk;
   logic        rst;
   logic        send;
   logic [39:0] data;
   logic        send_done;
   logic        tx;
   logic        busy;

   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   uart_frame_tx #(
      .CLKS_PER_BIT(CPB),
      .DATA_W      (40)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .send     (send),
      .data     (data),
      .send_done(send_done),
      .tx       (tx),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Line monitor: start detected at cycle 0, bits sampled mid-period.
   initial begin
      int         mcnt;
      logic       mact;
      logic [7:0] msh;
      logic [7:0] e;
      mact = 1'b0;
      mcnt = 0;
      msh  = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            mact = 1'b0;
         end else if (!mact) begin
            if (tx === 1'b0) begin
               mact = 1'b1;
               mcnt = 0;
            end
         end else begin
            mcnt++;
            if (mcnt == 2) chk("start_bit", 64'(tx), 64'd0);
            if (mcnt >= 6 && mcnt <= 34 && ((mcnt - 2) % 4) == 0)
               msh[3'((mcnt - 6) / 4)] = tx;
            if (mcnt == 38) begin
               chk("stop_bit", 64'(tx), 64'd1);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_byte: got %0h, expected no byte", msh);
               end else begin
                  e = exp_q.pop_front();
                  chk("byte", 64'(msh), 64'(e));
               end
               mact = 1'b0;
            end
         end
      end
   end

   task automatic frame(input logic [39:0] d, input int drop_at, input int change_at,
                        input bit release_rst);
      int k, bc, done_k;
      @(negedge clk);
      data = d;
      send = 1'b1;
      if (release_rst) rst = 1'b1;
      for (int b = 4; b >= 0; b--) exp_q.push_back(d[8*b +: 8]);
      k      = 0;
      bc     = 0;
      done_k = 0;
      while (done_k == 0 && k < 1000) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            chk("start_latency_tx", 64'(tx), 64'd0);
            chk("start_latency_busy", 64'(busy), 64'd1);
         end
         if (busy) bc++;
         if (send_done) done_k = k;
         if (k == drop_at) send = 1'b0;
         if (k == change_at) data = '0;
      end
      chk("busy_cycles", 64'(bc), 64'd200);
      chk("done_cycle", 64'(done_k), 64'd201);
   endtask

   initial begin
      int bc, tl;
      rst  = 1'b0;
      send = 1'b0;
      data = '0;
      @(negedge clk);
      chk("reset_tx", 64'(tx), 64'd1);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(send_done), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      frame(40'hFFFFFFFFFF, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk("done_held", 64'(send_done), 64'd1);
      send = 1'b0;
      @(negedge clk);
      chk("done_release", 64'(send_done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      frame(40'h0102030405, 0, 0, 1'b0);
      bc = 0;
      tl = 0;
      repeat (500) begin
         @(negedge clk);
         if (busy) bc++;
         if (!tx) tl++;
      end
      chk("hold_busy", 64'(bc), 64'd0);
      chk("hold_txlow", 64'(tl), 64'd0);
      chk("hold_done", 64'(send_done), 64'd1);

      send = 1'b0;
      frame(40'hDEADBEEF42, 0, 30, 1'b0);
      @(negedge clk);
      send = 1'b0;
      @(negedge clk);
      chk("done_release2", 64'(send_done), 64'd0);

      @(negedge clk);
      data = 40'h1122334455;
      send = 1'b1;
      for (int b = 4; b >= 0; b--) exp_q.push_back(data[8*b +: 8]);
      repeat (57) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("midreset_tx", 64'(tx), 64'd1);
      chk("midreset_busy", 64'(busy), 64'd0);
      chk("midreset_done", 64'(send_done), 64'd0);
      exp_q.delete();
      data = 40'h3C5A9612F0;
      repeat (2) @(negedge clk);
      chk("inreset_tx", 64'(tx), 64'd1);
      frame(40'h3C5A9612F0, 0, 0, 1'b1);
      @(negedge clk);
      send = 1'b0;
      @(negedge clk);
      chk("done_release3", 64'(send_done), 64'd0);

      frame(40'h8001FE7F11, 20, 0, 1'b0);
      @(negedge clk);
      chk("pulse_end", 64'(send_done), 64'd0);
      bc = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy || send_done) bc++;
      end
      chk("back_to_idle", 64'(bc), 64'd0);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
